fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset PC and the fetch buffer entry.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    instr_t          instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO between fetch and decode; clear empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1'b1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy; clear takes priority over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order imem
// requests, and buffers returned words with their PC for decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  instr_t          imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output instr_t          instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_next_s;
  logic [XLEN-1:0]  rsp_pc_r;
  logic [XLEN-1:0]  rsp_pc_next_s;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] outstanding_next_s;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] drop_cnt_next_s;
  logic [CNT_W-1:0] occupancy_s;
  logic [CRD_W-1:0] credit_s;
  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             empty_s;
  logic             unused_full_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_entry_s;

  assign pop_s          = instr_valid && instr_ready;
  // Same-cycle pop frees a slot, so DEPTH=2 sustains one fetch per cycle.
  assign credit_s       = CRD_W'(outstanding_r) + CRD_W'(occupancy_s) - CRD_W'(pop_s);
  assign imem_req_valid = !reset && (credit_s < CRD_W'(DEPTH));
  assign imem_req_addr  = pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;
  // rsp_pc_r tracks the address of the next response that will be kept.
  assign push_s         = imem_rsp_valid && (drop_cnt_r == '0) && !redirect_valid;
  assign push_entry_s   = '{instr: imem_rsp_data, pc: rsp_pc_r, pc_plus4: pc_inc(rsp_pc_r)};

  // Next PC, response tail PC, in-flight count and stale-response count.
  always_comb begin
    pc_next_s          = pc_r;
    rsp_pc_next_s      = rsp_pc_r;
    drop_cnt_next_s    = drop_cnt_r;
    outstanding_next_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_next_s       = pc_align(redirect_pc);
      rsp_pc_next_s   = pc_align(redirect_pc);
      drop_cnt_next_s = outstanding_next_s;
    end else begin
      if (accept_s) begin
        pc_next_s = pc_inc(pc_r);
      end else begin
        pc_next_s = pc_r;
      end
      if (push_s) begin
        rsp_pc_next_s = pc_inc(rsp_pc_r);
      end else begin
        rsp_pc_next_s = rsp_pc_r;
      end
      if (imem_rsp_valid && (drop_cnt_r != '0)) begin
        drop_cnt_next_s = drop_cnt_r - CNT_W'(1'b1);
      end else begin
        drop_cnt_next_s = drop_cnt_r;
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      pc_r          <= pc_next_s;
      rsp_pc_r      <= rsp_pc_next_s;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_cnt_next_s;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .clear     (redirect_valid),
    .head_data (head_entry_s),
    .full      (unused_full_s),
    .empty     (empty_s),
    .count     (occupancy_s)
  );

  assign instr_valid    = !empty_s;
  assign instr          = head_entry_s.instr;
  assign instr_pc       = head_entry_s.pc;
  assign instr_pc_plus4 = head_entry_s.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based memory model and an in-order PC scoreboard.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_ready;
  logic        a_req_valid, a_ivalid, b_req_valid, b_ivalid;
  logic [31:0] a_req_addr, a_instr, a_pc, a_pc4;
  logic [31:0] b_req_addr, b_instr, b_pc, b_pc4;

  fetch_unit #(.RESET_PC(RPC_A), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(a_ivalid), .instr_ready(instr_ready), .instr(a_instr),
    .instr_pc(a_pc), .instr_pc_plus4(a_pc4)
  );

  fetch_unit #(.RESET_PC(RPC_B), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(b_ivalid), .instr_ready(instr_ready), .instr(b_instr),
    .instr_pc(b_pc), .instr_pc_plus4(b_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t       mq[$];
  int          lat;
  int          cyc;
  int          errors;
  int          checks;
  logic [31:0] exp_req;
  logic [31:0] exp_pc;
  logic        o_acc, o_pop, o_rsp, o_ivalid, o_reqv, b_acc, b_pop;
  logic [31:0] o_addr, o_pc, o_instr, b_addr, b_pcv, b_pc4v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle, entered and left at a falling edge; main DUT scoreboarded here.
  task automatic cycle(input logic rdy, input logic mrdy, input logic redir, input logic [31:0] rpc);
    mreq_t e;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      e = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(e.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    o_rsp = imem_rsp_valid; o_ivalid = a_ivalid; o_reqv = a_req_valid;
    o_addr = a_req_addr; o_pc = a_pc; o_instr = a_instr;
    o_acc = a_req_valid && imem_req_ready;
    o_pop = a_ivalid && instr_ready;
    b_acc = b_req_valid && imem_req_ready; b_addr = b_req_addr;
    b_pop = b_ivalid && instr_ready; b_pcv = b_pc; b_pc4v = b_pc4;
    if (o_acc) begin
      checks++;
      if (a_req_addr !== exp_req) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, a_req_addr, exp_req);
      end
      mq.push_back('{cyc + lat, a_req_addr});
      exp_req = exp_req + 32'd4;
    end
    if (o_pop) begin
      checks++;
      if (a_pc !== exp_pc || a_instr !== mem_word(exp_pc) || a_pc4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL deliver cyc=%0d got pc=%h instr=%h pc4=%h exp pc=%h instr=%h",
                 cyc, a_pc, a_instr, a_pc4, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    checks++;
    if (mq.size() > DEPTH) begin
      errors++;
      $display("FAIL in_flight cyc=%0d got=%0d max=%0d", cyc, mq.size(), DEPTH);
    end
    if (redir) begin
      exp_req = {rpc[31:2], 2'b00};
      exp_pc  = {rpc[31:2], 2'b00};
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; instr_ready = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_req = RPC_A; exp_pc = RPC_A;
  endtask

  task automatic test_reset();
    int first_v;
    @(negedge clk);
    #1;
    checks++;
    if (a_req_valid !== 1'b0 || a_ivalid !== 1'b0) begin
      errors++; $display("FAIL reset_valids got req=%b iv=%b exp 0 0", a_req_valid, a_ivalid);
    end
    checks++;
    if (a_instr !== 32'd0 || a_pc !== 32'd0 || a_pc4 !== 32'd0) begin
      errors++; $display("FAIL reset_head got %h %h %h exp zeros", a_instr, a_pc, a_pc4);
    end
    checks++;
    if (a_req_addr !== RPC_A || b_req_addr !== RPC_B) begin
      errors++; $display("FAIL reset_addr got %h %h exp %h %h", a_req_addr, b_req_addr, RPC_A, RPC_B);
    end
    @(negedge clk);
    reset = 1'b0; exp_req = RPC_A; exp_pc = RPC_A; lat = 1;
    first_v = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (i == 0) begin
        checks++;
        if (o_acc !== 1'b1) begin
          errors++; $display("FAIL first_req got valid=%b exp 1", o_reqv);
        end
      end
      if (o_ivalid && first_v < 0) first_v = i;
    end
    checks++;
    if (first_v != 2) begin
      errors++; $display("FAIL first_instr_valid got cycle %0d exp 2", first_v);
    end
  endtask

  task automatic test_stream();
    int pops = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (o_pop) pops++;
    end
    checks++;
    if (pops != 20) begin
      errors++; $display("FAIL stream_rate got %0d exp 20", pops);
    end
  endtask

  task automatic test_stall();
    int accs = 0;
    int pops = 0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      if (o_acc) accs++;
      if (i >= 2) begin
        checks++;
        if (o_ivalid !== 1'b1 || o_pc !== 32'd0 || o_instr !== mem_word(32'd0)) begin
          errors++; $display("FAIL stall_head cyc=%0d got v=%b pc=%h instr=%h exp 1 0 %h",
                             i, o_ivalid, o_pc, o_instr, mem_word(32'd0));
        end
      end
    end
    checks++;
    if (accs != DEPTH || o_reqv !== 1'b0) begin
      errors++; $display("FAIL stall_credits got reqs=%0d valid=%b exp %0d 0", accs, o_reqv, DEPTH);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (o_pop) pops++;
    end
    checks++;
    if (pops != 10) begin
      errors++; $display("FAIL stall_release got %0d exp 10", pops);
    end
  endtask

  // Run until the first delivery and require it to be the redirect target.
  task automatic wait_first(input logic [31:0] tgt, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (o_pop) begin
        seen = 1'b1;
        checks++;
        if (o_pc !== tgt) begin
          errors++; $display("FAIL %s first_pc got %h exp %h", name, o_pc, tgt);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout got no delivery exp pc %h", name, tgt);
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (o_ivalid !== 1'b0 || o_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL inflight_after got v=%b addr=%h exp 0 00000100", o_ivalid, o_addr);
    end
    wait_first(32'h0000_0100, "inflight");
  endtask

  task automatic test_redirect_accept();
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    checks++;
    if (o_acc !== 1'b1 || o_rsp !== 1'b1) begin
      errors++; $display("FAIL redir_acc_rsp got acc=%b rsp=%b exp 1 1", o_acc, o_rsp);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (o_ivalid !== 1'b0) begin
      errors++; $display("FAIL redir_flush got v=%b exp 0", o_ivalid);
    end
    wait_first(32'h0000_0200, "acc_rsp");
    lat = 3;
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    checks++;
    if (o_acc !== 1'b1 || o_rsp !== 1'b0) begin
      errors++; $display("FAIL redir_acc_only got acc=%b rsp=%b exp 1 0", o_acc, o_rsp);
    end
    wait_first(32'h0000_0300, "acc_only");
  endtask

  task automatic test_reset_pc();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] pc4s[$];
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (b_acc) addrs.push_back(b_addr);
      if (b_pop) begin pcs.push_back(b_pcv); pc4s.push_back(b_pc4v); end
    end
    checks++;
    if (addrs.size() < 3 || addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_req got n=%0d first=%h exp FFFFFFF8 FFFFFFFC 0",
                         addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hx);
    end
    checks++;
    if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFF8 || pc4s[0] !== 32'hFFFF_FFFC ||
        pcs[1] !== 32'hFFFF_FFFC || pc4s[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4 got n=%0d exp pcs FFFFFFF8/FFFFFFFC pc4 FFFFFFFC/0", pcs.size());
    end
  endtask

  task automatic test_random();
    int          pops;
    logic        rdy, mrdy, rd;
    logic [31:0] tgt;
    for (int k = 0; k < 3; k++) begin
      lat = $urandom_range(1, 4);
      do_reset();
      pops = 0;
      for (int i = 0; i < 300; i++) begin
        rdy  = ($urandom_range(0, 3) != 0);
        mrdy = ($urandom_range(0, 4) != 0);
        rd   = ($urandom_range(0, 19) == 0);
        tgt  = $urandom;
        cycle(rdy, mrdy, rd, tgt);
        if (o_pop) pops++;
      end
      checks++;
      if (pops < 20) begin
        errors++; $display("FAIL random_progress lat=%0d got %0d exp >=20", lat, pops);
      end
    end
  endtask

  task automatic test_reset_midstream();
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (o_ivalid !== 1'b1 || o_reqv !== 1'b0) begin
      errors++; $display("FAIL mid_full got v=%b req=%b exp 1 0", o_ivalid, o_reqv);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (a_req_valid !== 1'b0 || a_ivalid !== 1'b0 || a_instr !== 32'd0 ||
        a_pc !== 32'd0 || a_pc4 !== 32'd0 || a_req_addr !== RPC_A) begin
      errors++; $display("FAIL mid_reset got req=%b v=%b instr=%h pc=%h pc4=%h addr=%h exp all 0",
                         a_req_valid, a_ivalid, a_instr, a_pc, a_pc4, a_req_addr);
    end
    mq.delete();
    @(negedge clk);
    reset = 1'b0; exp_req = RPC_A; exp_pc = RPC_A;
    wait_first(RPC_A, "restart");
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 1;
    reset = 1'b1; instr_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    exp_req = RPC_A; exp_pc = RPC_A;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_accept();
    test_reset_pc();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
